// File: rtl/cache_fill_responder.sv
// Line-fill responder: fetches a cacheline from the SDRAM core as one linear burst and replays it critical-word-first.
// Fill strobe comes one cycle after the last read word (or after the write ack); commands are held until mem_ack.
module cache_fill_responder #(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_rw,
   input  logic [15:0]       req_wdata,
   output logic              fill,
   output logic [15:0]       fill_data,
   output logic              busy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata
);

   localparam int                IW        = $clog2(LINE_WORDS);
   localparam logic [IW-1:0]     LAST      = IW'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << (IW + 1)) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CMD,
      S_RD_COLLECT,
      S_EMIT,
      S_WR_CMD,
      S_WR_DONE,
      S_RELEASE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic [IW-1:0]     r_cnt;
   logic [IW-1:0]     r_k;
   logic [15:0]       r_line [LINE_WORDS];
   logic [IW-1:0]     w_crit;
   logic [IW-1:0]     w_idx;
   logic              w_capture;

   assign w_crit = r_addr[IW:1];
   assign w_idx  = w_crit + r_k;

   // A word arriving together with the command ack is the first word of the burst.
   assign w_capture = mem_rvalid &&
                      ((r_state == S_RD_CMD && mem_ack) || r_state == S_RD_COLLECT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (req) w_next = req_rw ? S_RD_CMD : S_WR_CMD;
         S_RD_CMD:     if (mem_ack) w_next = S_RD_COLLECT;
         S_RD_COLLECT: if (mem_rvalid && r_cnt == LAST) w_next = S_EMIT;
         S_EMIT:       if (r_k == LAST) w_next = S_RELEASE;
         S_WR_CMD:     if (mem_ack) w_next = S_WR_DONE;
         S_WR_DONE:    w_next = S_RELEASE;
         S_RELEASE:    if (!req) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      fill      = 1'b0;
      fill_data = '0;
      busy      = (r_state != S_IDLE);
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_rw    = 1'b0;
      mem_wdata = '0;
      case (r_state)
         S_RD_CMD: begin
            mem_req  = 1'b1;
            mem_rw   = 1'b1;
            mem_addr = r_addr & ~LINE_MASK;
         end
         S_EMIT: begin
            fill      = (r_k == '0);
            fill_data = r_line[w_idx];
         end
         S_WR_CMD: begin
            mem_req   = 1'b1;
            mem_addr  = r_addr & ~ADDR_W'(1);
            mem_wdata = r_wdata;
         end
         S_WR_DONE: fill = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_cnt   <= '0;
                  r_k     <= '0;
               end
            end
            S_RD_CMD, S_RD_COLLECT: if (w_capture) r_cnt <= r_cnt + 1'b1;
            S_EMIT:                 r_k <= r_k + 1'b1;
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; a discarded partial line is simply overwritten.
   always_ff @(posedge clk) begin
      if (reset && w_capture) begin
         r_line[r_cnt] <= mem_rdata;
      end
   end

endmodule
